mdio_access_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing the single MDIO management engine (MDC/MDIO serial

---
 rtl/mdio_access_arbiter_pkg.sv | 35 +++
 rtl/mdio_access_arbiter_rr_arbiter.sv | 41 ++++
 rtl/mdio_access_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mdio_access_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_access_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mdio_access_arbiter_pkg
//  Shared definitions for the MDIO access arbiter:
//   - sequencer state encoding (IDLE/ISSUE/WAIT/DONE)
//   - clause-22 MDIO command word field offsets
//   - position of the read-data-valid flag in the engine result word
//   - helper to size the round-robin pointer / owner index
//  No ports (package).
// -----------------------------------------------------------------------------
package mdio_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  // Command word layout: ST[31:30] OP[29:28] PHYAD[27:23] REGAD[22:18] TA[17:16] DATA[15:0]
  localparam int CMD_ST_LSB    = 30;
  localparam int CMD_OP_LSB    = 28;
  localparam int CMD_PHYAD_LSB = 23;
  localparam int CMD_REGAD_LSB = 18;
  localparam int CMD_TA_LSB    = 16;
  localparam int CMD_DATA_LSB  = 0;

  // Engine result word: bit 24 flags valid read data
  localparam int RDATA_VALID_BIT = 24;

  // Index width for n requesters; never below one bit
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mdio_access_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mdio_access_arbiter_rr_arbiter
//  Combinational round-robin pick: first set request bit at or after the
//  pointer, wrapping at NUM_REQ.
//  Ports:
//   req  in  NUM_REQ  request vector
//   ptr  in  PTR_W    highest-priority requester index
//   gnt  out NUM_REQ  one-hot winner (all zero when no request)
//   idx  out PTR_W    winner index (0 when no request)
// -----------------------------------------------------------------------------
module mdio_access_arbiter_rr_arbiter
  import mdio_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx
);

  logic             found;
  logic [PTR_W-1:0] k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[k]) begin
        gnt[k] = 1'b1;
        idx    = k;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mdio_access_arbiter.sv
// -----------------------------------------------------------------------------
// mdio_access_arbiter
//  Round-robin sequencer sharing one MDIO management engine among NUM_REQ
//  requesters. One command in flight; result and a done pulse go back to the
//  owner. Single clock OPB_CLK, synchronous active-high OPB_RST.
//
//  Optional build macro: MDIO_ARB_TIMEOUT_EN
//   defined   - outstanding command abandoned after TIMEOUT_CYC cycles in
//               ISSUE/WAIT (err_o=1, rdata_o=0, normal done pulse)
//   undefined - waits indefinitely, err_o tied 0
//
//  Ports:
//   OPB_CLK      in   clock
//   OPB_RST      in   synchronous reset, active high
//   req_i        in   level request per requester
//   cmd_i        in   command words, requester k at [32k+31:32k]
//   gnt_o        out  one-hot owner, grant through done cycle
//   done_o       out  one-cycle completion pulse to owner
//   rdata_o      out  engine result, held until next done
//   err_o        out  timeout flag, valid with done_o
//   eng_valid_o  out  command valid to engine
//   eng_ready_i  in   engine accepts command
//   eng_cmd_o    out  latched command word
//   eng_done_i   in   engine completion pulse
//   eng_rdata_i  in   engine result word
//
//  state  | meaning
//  IDLE   | no owner; pick winner and latch its command
//  ISSUE  | eng_valid_o high, waiting for eng_ready_i
//  WAIT   | command accepted, waiting for eng_done_i
//  DONE   | done_o pulse to owner; release grant, advance pointer
// -----------------------------------------------------------------------------
module mdio_access_arbiter
  import mdio_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  OPB_CLK,
  input  logic                  OPB_RST,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [32*NUM_REQ-1:0] cmd_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  eng_valid_o,
  input  logic                  eng_ready_i,
  output logic [31:0]           eng_cmd_o,
  input  logic                  eng_done_i,
  input  logic [31:0]           eng_rdata_i
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("mdio_access_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 2");
  end

  arb_state_t         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   next_ptr;

  mdio_access_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req (req_i),
    .ptr (rr_ptr),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  assign next_ptr = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);

`ifdef MDIO_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMR_W-1:0] tmr_cnt;
  logic             tmr_expired;

  // Loaded on grant so the TIMEOUT_CYC-th cycle spent in ISSUE/WAIT sees zero
  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      tmr_cnt <= '0;
    end else if (state == ST_IDLE) begin
      tmr_cnt <= TMR_W'(TIMEOUT_CYC - 1);
    end else if ((state == ST_ISSUE || state == ST_WAIT) && tmr_cnt != '0) begin
      tmr_cnt <= tmr_cnt - TMR_W'(1);
    end
  end

  assign tmr_expired = (state == ST_ISSUE || state == ST_WAIT) && (tmr_cnt == '0);
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      owner_idx   <= '0;
      gnt_o       <= '0;
      done_o      <= '0;
      rdata_o     <= '0;
      eng_valid_o <= 1'b0;
      eng_cmd_o   <= '0;
`ifdef MDIO_ARB_TIMEOUT_EN
      err_o       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done_o <= '0;
          if (|req_i) begin
            gnt_o       <= win_gnt;
            owner_idx   <= win_idx;
            eng_cmd_o   <= cmd_i[32*int'(win_idx) +: 32];
            eng_valid_o <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // An accept in the expiry cycle still counts; the command is with the engine
          if (eng_ready_i) begin
            eng_valid_o <= 1'b0;
            state       <= ST_WAIT;
          end
`ifdef MDIO_ARB_TIMEOUT_EN
          else if (tmr_expired) begin
            eng_valid_o <= 1'b0;
            rdata_o     <= '0;
            err_o       <= 1'b1;
            done_o      <= gnt_o;
            state       <= ST_DONE;
          end
`endif
        end
        ST_WAIT: begin
          // Completion wins over expiry in the same cycle
          if (eng_done_i) begin
            rdata_o <= eng_rdata_i;
            done_o  <= gnt_o;
`ifdef MDIO_ARB_TIMEOUT_EN
            err_o   <= 1'b0;
`endif
            state   <= ST_DONE;
          end
`ifdef MDIO_ARB_TIMEOUT_EN
          else if (tmr_expired) begin
            rdata_o <= '0;
            err_o   <= 1'b1;
            done_o  <= gnt_o;
            state   <= ST_DONE;
          end
`endif
        end
        ST_DONE: begin
          done_o <= '0;
          gnt_o  <= '0;
          rr_ptr <= next_ptr;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_access_arbiter.sv
module tb_mdio_access_arbiter;

  logic         OPB_CLK;
  logic         OPB_RST;
  logic [3:0]   req_i;
  logic [127:0] cmd_i;
  logic [3:0]   gnt_o;
  logic [3:0]   done_o;
  logic [31:0]  rdata_o;
  logic         err_o;
  logic         eng_valid_o;
  logic         eng_ready_i;
  logic [31:0]  eng_cmd_o;
  logic         eng_done_i;
  logic [31:0]  eng_rdata_i;

  int tests_run;
  int tests_failed;

  mdio_access_arbiter #(
    .NUM_REQ     (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .OPB_CLK     (OPB_CLK),
    .OPB_RST     (OPB_RST),
    .req_i       (req_i),
    .cmd_i       (cmd_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .eng_valid_o (eng_valid_o),
    .eng_ready_i (eng_ready_i),
    .eng_cmd_o   (eng_cmd_o),
    .eng_done_i  (eng_done_i),
    .eng_rdata_i (eng_rdata_i)
  );

  initial OPB_CLK = 1'b0;
  always #5 OPB_CLK = ~OPB_CLK;

  task automatic tick();
    @(posedge OPB_CLK);
    #1;
  endtask

  task automatic do_reset();
    OPB_RST     = 1'b1;
    req_i       = 4'h0;
    eng_ready_i = 1'b0;
    eng_done_i  = 1'b0;
    tick();
    tick();
    OPB_RST = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt_o != 4'h0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Accept now, complete lat cycles later; returns in the DONE cycle
  task automatic serve(input logic [31:0] rd, input int lat);
    eng_ready_i = 1'b1;
    tick();
    eng_ready_i = 1'b0;
    for (int i = 0; i < lat - 1; i++) tick();
    eng_done_i  = 1'b1;
    eng_rdata_i = rd;
    tick();
    eng_done_i  = 1'b0;
  endtask

  task automatic test_reset();
    OPB_RST     = 1'b1;
    req_i       = 4'hF;
    cmd_i       = {4{32'h1234_5678}};
    eng_ready_i = 1'b1;
    eng_done_i  = 1'b0;
    eng_rdata_i = 32'h0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (gnt_o !== 4'h0 || done_o !== 4'h0 || rdata_o !== 32'h0 || err_o !== 1'b0 ||
          eng_valid_o !== 1'b0 || eng_cmd_o !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_outputs cycle %0d: gnt=%h done=%h rdata=%h err=%b valid=%b cmd=%h, required all 0",
                 c, gnt_o, done_o, rdata_o, err_o, eng_valid_o, eng_cmd_o);
      end
    end
    req_i       = 4'h0;
    eng_ready_i = 1'b0;
    OPB_RST     = 1'b0;
    tick();
    tests_run++;
    if (eng_valid_o !== 1'b0 || gnt_o !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: valid=%b gnt=%h, required 0/0", eng_valid_o, gnt_o);
    end
  endtask

  task automatic test_single();
    cmd_i[95:64] = 32'h6012_0000;
    eng_ready_i  = 1'b1;
    req_i        = 4'b0100;
    tick();
    tests_run++;
    if (gnt_o !== 4'b0100 || eng_valid_o !== 1'b1 || eng_cmd_o !== 32'h6012_0000) begin
      tests_failed++;
      $display("FAIL single_grant: gnt=%b valid=%b cmd=%h, required 0100/1/60120000",
               gnt_o, eng_valid_o, eng_cmd_o);
    end
    tick();
    eng_ready_i = 1'b0;
    tests_run++;
    if (eng_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_accept: valid=%b, required 0", eng_valid_o);
    end
    for (int i = 0; i < 19; i++) tick();
    eng_done_i  = 1'b1;
    eng_rdata_i = 32'h0100_1234;
    tick();
    eng_done_i = 1'b0;
    req_i      = 4'h0;
    tests_run++;
    if (done_o !== 4'b0100 || rdata_o !== 32'h0100_1234 || err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: done=%b rdata=%h err=%b, required 0100/01001234/0",
               done_o, rdata_o, err_o);
    end
    tick();
    tests_run++;
    if (done_o !== 4'h0 || gnt_o !== 4'h0 || rdata_o !== 32'h0100_1234) begin
      tests_failed++;
      $display("FAIL single_release: done=%b gnt=%b rdata=%h, required 0000/0000/01001234",
               done_o, gnt_o, rdata_o);
    end
  endtask

  task automatic test_fairness();
    bit         ok;
    int         exp;
    logic [3:0] exp_oh;
    do_reset();
    for (int k = 0; k < 4; k++) cmd_i[32*k +: 32] = 32'hA000_0000 + k;
    req_i = 4'hF;
    exp   = 0;
    for (int n = 0; n < 16; n++) begin
      exp_oh = 4'b0001 << exp;
      wait_grant(ok);
      tests_run++;
      if (!ok || gnt_o !== exp_oh || eng_cmd_o !== 32'hA000_0000 + exp) begin
        tests_failed++;
        $display("FAIL fair_grant txn %0d: gnt=%b cmd=%h, required %b/%h",
                 n, gnt_o, eng_cmd_o, exp_oh, 32'hA000_0000 + exp);
      end
      serve(32'h0100_0000 + n, 2);
      tests_run++;
      if (done_o !== exp_oh || rdata_o !== 32'h0100_0000 + n) begin
        tests_failed++;
        $display("FAIL fair_done txn %0d: done=%b rdata=%h, required %b/%h",
                 n, done_o, rdata_o, exp_oh, 32'h0100_0000 + n);
      end
      exp = (exp + 1) % 4;
    end
    req_i = 4'h0;
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    cmd_i[63:32] = 32'h5555_AAAA;
    eng_ready_i  = 1'b0;
    req_i        = 4'b0010;
    wait_grant(ok);
    tests_run++;
    if (!ok || gnt_o !== 4'b0010) begin
      tests_failed++;
      $display("FAIL bp_grant: gnt=%b, required 0010", gnt_o);
    end
    cmd_i[63:32] = 32'h0000_0000;
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (eng_valid_o !== 1'b1 || eng_cmd_o !== 32'h5555_AAAA) begin
        tests_failed++;
        $display("FAIL bp_hold cycle %0d: valid=%b cmd=%h, required 1/5555aaaa",
                 i, eng_valid_o, eng_cmd_o);
      end
      tick();
    end
    eng_ready_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (eng_valid_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_single_accept cycle %0d: valid=%b, required 0", i, eng_valid_o);
      end
      tick();
    end
    eng_ready_i = 1'b0;
    eng_done_i  = 1'b1;
    eng_rdata_i = 32'h0000_BEEF;
    tick();
    eng_done_i = 1'b0;
    req_i      = 4'h0;
    tests_run++;
    if (done_o !== 4'b0010 || rdata_o !== 32'h0000_BEEF) begin
      tests_failed++;
      $display("FAIL bp_done: done=%b rdata=%h, required 0010/0000beef", done_o, rdata_o);
    end
    tick();
  endtask

  task automatic test_spurious_abort();
    bit ok;
    tick();
    eng_done_i  = 1'b1;
    eng_rdata_i = 32'hDEAD_BEEF;
    tick();
    eng_done_i = 1'b0;
    tests_run++;
    if (done_o !== 4'h0) begin
      tests_failed++;
      $display("FAIL spurious_done: done=%b, required 0000", done_o);
    end
    tick();
    tests_run++;
    if (done_o !== 4'h0 || rdata_o !== 32'h0000_BEEF) begin
      tests_failed++;
      $display("FAIL spurious_rdata: done=%b rdata=%h, required 0000/0000beef", done_o, rdata_o);
    end
    cmd_i[127:96] = 32'h6C40_0000;
    req_i         = 4'b1000;
    wait_grant(ok);
    tests_run++;
    if (!ok || gnt_o !== 4'b1000 || eng_cmd_o !== 32'h6C40_0000) begin
      tests_failed++;
      $display("FAIL abort_grant: gnt=%b cmd=%h, required 1000/6c400000", gnt_o, eng_cmd_o);
    end
    eng_ready_i = 1'b1;
    tick();
    eng_ready_i = 1'b0;
    req_i       = 4'h0;
    for (int i = 0; i < 3; i++) tick();
    eng_done_i  = 1'b1;
    eng_rdata_i = 32'h0100_0077;
    tick();
    eng_done_i = 1'b0;
    tests_run++;
    if (done_o !== 4'b1000 || rdata_o !== 32'h0100_0077) begin
      tests_failed++;
      $display("FAIL abort_done: done=%b rdata=%h, required 1000/01000077", done_o, rdata_o);
    end
    tick();
    tests_run++;
    if (gnt_o !== 4'h0 || done_o !== 4'h0) begin
      tests_failed++;
      $display("FAIL abort_release: gnt=%b done=%b, required 0000/0000", gnt_o, done_o);
    end
  endtask

`ifdef MDIO_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int cyc;
    do_reset();
    cmd_i[31:0] = 32'h6000_0000;
    cmd_i[63:32] = 32'h6100_0000;
    req_i = 4'b0011;
    wait_grant(ok);
    tests_run++;
    if (!ok || gnt_o !== 4'b0001) begin
      tests_failed++;
      $display("FAIL to_grant: gnt=%b, required 0001", gnt_o);
    end
    eng_ready_i = 1'b1;
    tick();
    eng_ready_i = 1'b0;
    cyc = 1;
    ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      cyc++;
      if (done_o != 4'h0) begin
        ok = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!ok || done_o !== 4'b0001 || err_o !== 1'b1 || rdata_o !== 32'h0 || cyc < 95 || cyc > 105) begin
      tests_failed++;
      $display("FAIL to_done: seen=%b done=%b err=%b rdata=%h cycles=%0d, required 1/0001/1/0/~100",
               ok, done_o, err_o, rdata_o, cyc);
    end
    req_i = 4'b0010;
    wait_grant(ok);
    tests_run++;
    if (!ok || gnt_o !== 4'b0010) begin
      tests_failed++;
      $display("FAIL to_next_grant: gnt=%b, required 0010", gnt_o);
    end
    serve(32'h0100_0001, 2);
    tests_run++;
    if (done_o !== 4'b0010 || err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_next_done: done=%b err=%b, required 0010/0", done_o, err_o);
    end
    req_i = 4'h0;
    tick();
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_spurious_abort();
`ifdef MDIO_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
